// File: rtl/music_fader_mixer.sv
// Final audio stage: scales music and effect sample pairs by 8-bit gains, sums with saturation,
// and runs a vblank-paced fade of the music gain under CPU control.
module music_fader_mixer #(
    parameter logic [7:0] DEFAULT_GAIN = 8'hFF,
    parameter int         FADE_DIV_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_sample,
    input  logic        vblank,
    input  logic [1:0]  addr,
    input  logic [7:0]  data_in,
    input  logic        write,
    input  logic [15:0] music_l,
    input  logic [15:0] music_r,
    input  logic [15:0] sfx_l,
    input  logic [15:0] sfx_r,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        fade_busy,
    output logic        music_muted
);
    localparam int DATA_W = 16;
    localparam int COEF_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

    // 8'hFF means unity, so full scale passes through unattenuated.
    function automatic logic [COEF_W:0] f_gain_factor(input logic [COEF_W-1:0] g);
        return (g == 8'hFF) ? 9'd256 : {1'b0, g};
    endfunction

    function automatic logic [DATA_W-1:0] f_scale(input logic [DATA_W-1:0] s,
                                                  input logic [COEF_W-1:0] g);
        logic [24:0] prod;
        prod = {9'd0, s} * {16'd0, f_gain_factor(g)};
        return 16'(prod >> 8);
    endfunction

    function automatic logic [DATA_W-1:0] f_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? 16'hFFFF : sum[DATA_W-1:0];
    endfunction

    state_t                r_state, w_state_nxt;
    logic [COEF_W-1:0]     r_target, r_sfx_gain, r_step, r_mgain, w_mgain_nxt;
    logic [FADE_DIV_W-1:0] r_cnt, w_cnt_nxt, r_div, w_div_nxt;
    logic [FADE_DIV_W-1:0] w_div_field, w_div_eff, w_cnt_last;
    logic                  r_dir, w_dir_nxt, r_vblank_q;
    logic                  w_start, w_vedge;
    logic [COEF_W-1:0]     w_fade_dn, w_fade_up;

    logic [DATA_W-1:0] r_ml_p1, r_mr_p1, r_sl_p1, r_sr_p1;
    logic [DATA_W-1:0] r_audio_l_p2, r_audio_r_p2;

    assign w_start     = write && (addr == 2'd2) && data_in[0];
    assign w_vedge     = vblank && !r_vblank_q;
    assign w_div_field = data_in[4 +: FADE_DIV_W];
    assign w_div_eff   = (w_div_field == '0) ? FADE_DIV_W'(1) : w_div_field;
    assign w_cnt_last  = r_div - FADE_DIV_W'(1);

    // Both directions clamp at their end point; fade-in from above the target snaps down to it.
    assign w_fade_dn = (r_mgain <= r_step) ? 8'd0 : r_mgain - r_step;
    assign w_fade_up = ((r_mgain >= r_target) || ((r_target - r_mgain) <= r_step))
                       ? r_target : r_mgain + r_step;

    always_comb begin
        w_state_nxt = r_state;
        w_mgain_nxt = r_mgain;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_div_nxt   = r_div;
        if (w_start) begin
            w_cnt_nxt   = '0;
            w_dir_nxt   = data_in[1];
            w_div_nxt   = w_div_eff;
            w_state_nxt = S_WAIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (write && (addr == 2'd0))
                        w_mgain_nxt = data_in;
                end
                S_WAIT: begin
                    if (w_vedge) begin
                        if (r_cnt == w_cnt_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_STEP;
                        end else begin
                            w_cnt_nxt = r_cnt + FADE_DIV_W'(1);
                        end
                    end
                end
                S_STEP: begin
                    if (r_dir) begin
                        w_mgain_nxt = w_fade_up;
                        w_state_nxt = (w_fade_up == r_target) ? S_IDLE : S_WAIT;
                    end else begin
                        w_mgain_nxt = w_fade_dn;
                        w_state_nxt = (w_fade_dn == 8'd0) ? S_IDLE : S_WAIT;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mgain    <= DEFAULT_GAIN;
            r_target   <= DEFAULT_GAIN;
            r_sfx_gain <= DEFAULT_GAIN;
            r_step     <= 8'd1;
            r_cnt      <= '0;
            r_div      <= FADE_DIV_W'(1);
            r_dir      <= 1'b0;
            r_vblank_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mgain    <= w_mgain_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_dir      <= w_dir_nxt;
            r_vblank_q <= vblank;
            if (write) begin
                case (addr)
                    2'd0:    r_target   <= data_in;
                    2'd1:    r_sfx_gain <= data_in;
                    2'd3:    r_step     <= (data_in == 8'd0) ? 8'd1 : data_in;
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: per-channel scaling; stage p2: saturating sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ml_p1      <= '0;
            r_mr_p1      <= '0;
            r_sl_p1      <= '0;
            r_sr_p1      <= '0;
            r_audio_l_p2 <= '0;
            r_audio_r_p2 <= '0;
        end else if (ce_sample) begin
            r_ml_p1      <= f_scale(music_l, r_mgain);
            r_mr_p1      <= f_scale(music_r, r_mgain);
            r_sl_p1      <= f_scale(sfx_l, r_sfx_gain);
            r_sr_p1      <= f_scale(sfx_r, r_sfx_gain);
            r_audio_l_p2 <= f_sat(r_ml_p1, r_sl_p1);
            r_audio_r_p2 <= f_sat(r_mr_p1, r_sr_p1);
        end
    end

    assign audio_l     = r_audio_l_p2;
    assign audio_r     = r_audio_r_p2;
    assign fade_busy   = (r_state != S_IDLE);
    assign music_muted = (r_mgain == 8'd0);

endmodule
